// File: rtl/cluster_sequencer_if.sv
// Control and memory-side bus between the cluster sequencer and its surroundings.
// The sequencer uses the slave view; the driving side uses the master view.
interface cluster_sequencer_if #(
   parameter int idSize   = 8,
   parameter int addrSize = 16
);
   logic                start_i;
   logic                abort_i;
   logic [7:0]          cfg_wcount;
   logic [7:0]          cfg_acount;
   logic [7:0]          cfg_ocount;
   logic [addrSize-1:0] cfg_w_base;
   logic [addrSize-1:0] cfg_a_base;
   logic [7:0]          id_idx_o;
   logic                id_wren_o;
   logic                w_rd_en_o;
   logic                a_rd_en_o;
   logic [addrSize-1:0] w_rd_addr_o;
   logic [addrSize-1:0] a_rd_addr_o;
   logic [idSize-1:0]   tag_x_o;
   logic [idSize-1:0]   tag_y_o;
   logic                tag_sel_w_o;
   logic                cast_valid_o;
   logic                start_compute_o;
   logic                pe_done_i;
   logic                outs_valid_i;
   logic                busy_o;
   logic                done_o;

   modport slave (
      input  start_i, abort_i, cfg_wcount, cfg_acount, cfg_ocount, cfg_w_base, cfg_a_base,
             pe_done_i, outs_valid_i,
      output id_idx_o, id_wren_o, w_rd_en_o, a_rd_en_o, w_rd_addr_o, a_rd_addr_o,
             tag_x_o, tag_y_o, tag_sel_w_o, cast_valid_o, start_compute_o, busy_o, done_o
   );

   modport master (
      output start_i, abort_i, cfg_wcount, cfg_acount, cfg_ocount, cfg_w_base, cfg_a_base,
             pe_done_i, outs_valid_i,
      input  id_idx_o, id_wren_o, w_rd_en_o, a_rd_en_o, w_rd_addr_o, a_rd_addr_o,
             tag_x_o, tag_y_o, tag_sel_w_o, cast_valid_o, start_compute_o, busy_o, done_o
   );
endinterface

// File: rtl/cluster_sequencer.sv
// Job sequencer for a PE cluster: ID scan, weight/activation multicast loads,
// compute trigger, output drain.
//
// state     | meaning
// S_IDLE    | waiting for start_i, config captured on accept
// S_SCAN    | shifting SCAN_LEN multicast IDs, index counting down
// S_LOADW   | one weight read per cycle over y/x/k
// S_LOADA   | one activation read per cycle over y/x/k
// S_COMPUTE | start_compute pulse, wait for pe_done (first cycle ignored)
// S_DRAIN   | counting output beats down to zero
// S_DONE    | single-cycle done pulse
module cluster_sequencer #(
   parameter int numPeX   = 3,
   parameter int numPeY   = 3,
   parameter int idSize   = 8,
   parameter int addrSize = 16
) (
   input  logic              clk,
   input  logic              nrst,
   cluster_sequencer_if.slave bus
);
   localparam int SCAN_LEN = numPeX*numPeY+numPeY;

   typedef enum logic [2:0] {
      S_IDLE, S_SCAN, S_LOADW, S_LOADA, S_COMPUTE, S_DRAIN, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [7:0]          x_q, x_d, y_q, y_d, k_q, k_d;
   logic [addrSize-1:0] addr_q, addr_d;
   logic                first_q, first_d;
   logic [7:0]          wcount_q, wcount_d, acount_q, acount_d, ocount_q, ocount_d;
   logic [addrSize-1:0] w_base_q, w_base_d, a_base_q, a_base_d;
   logic                cast_valid_q, cast_valid_d, tag_sel_w_q, tag_sel_w_d;
   logic [idSize-1:0]   tag_x_q, tag_x_d, tag_y_q, tag_y_d;

   logic                loading;
   logic [7:0]          load_cnt;
   logic                rd_active;
   logic                last_beat;

   assign loading   = (state_q == S_LOADW) || (state_q == S_LOADA);
   assign load_cnt  = (state_q == S_LOADW) ? wcount_q : acount_q;
   assign rd_active = loading && (load_cnt != 8'd0);
   assign last_beat = (k_q == load_cnt - 8'd1) && (x_q == 8'(numPeX-1)) && (y_q == 8'(numPeY-1));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         x_q          <= '0;
         y_q          <= '0;
         k_q          <= '0;
         addr_q       <= '0;
         first_q      <= 1'b0;
         wcount_q     <= '0;
         acount_q     <= '0;
         ocount_q     <= '0;
         w_base_q     <= '0;
         a_base_q     <= '0;
         cast_valid_q <= 1'b0;
         tag_sel_w_q  <= 1'b0;
         tag_x_q      <= '0;
         tag_y_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         x_q          <= x_d;
         y_q          <= y_d;
         k_q          <= k_d;
         addr_q       <= addr_d;
         first_q      <= first_d;
         wcount_q     <= wcount_d;
         acount_q     <= acount_d;
         ocount_q     <= ocount_d;
         w_base_q     <= w_base_d;
         a_base_q     <= a_base_d;
         cast_valid_q <= cast_valid_d;
         tag_sel_w_q  <= tag_sel_w_d;
         tag_x_q      <= tag_x_d;
         tag_y_q      <= tag_y_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      x_d          = x_q;
      y_d          = y_q;
      k_d          = k_q;
      addr_d       = addr_q;
      first_d      = 1'b0;
      wcount_d     = wcount_q;
      acount_d     = acount_q;
      ocount_d     = ocount_q;
      w_base_d     = w_base_q;
      a_base_d     = a_base_q;
      // Tags follow the read strobe by one cycle to line up with memory data.
      cast_valid_d = rd_active;
      tag_sel_w_d  = rd_active && (state_q == S_LOADW);
      tag_x_d      = rd_active ? idSize'(x_q) : '0;
      tag_y_d      = rd_active ? idSize'(y_q) : '0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               state_d  = S_SCAN;
               cnt_d    = 8'(SCAN_LEN-1);
               wcount_d = bus.cfg_wcount;
               acount_d = bus.cfg_acount;
               ocount_d = bus.cfg_ocount;
               w_base_d = bus.cfg_w_base;
               a_base_d = bus.cfg_a_base;
            end
         end
         S_SCAN: begin
            if (cnt_q == 8'd0) begin
               state_d = S_LOADW;
               addr_d  = w_base_q;
               x_d     = '0;
               y_d     = '0;
               k_d     = '0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_LOADW, S_LOADA: begin
            if (!rd_active || last_beat) begin
               x_d = '0;
               y_d = '0;
               k_d = '0;
               if (state_q == S_LOADW) begin
                  state_d = S_LOADA;
                  addr_d  = a_base_q;
               end else begin
                  state_d = S_COMPUTE;
                  first_d = 1'b1;
               end
            end else begin
               // Addresses are contiguous because k is the innermost loop.
               addr_d = addr_q + 1'b1;
               if (k_q == load_cnt - 8'd1) begin
                  k_d = '0;
                  if (x_q == 8'(numPeX-1)) begin
                     x_d = '0;
                     y_d = y_q + 8'd1;
                  end else begin
                     x_d = x_q + 8'd1;
                  end
               end else begin
                  k_d = k_q + 8'd1;
               end
            end
         end
         S_COMPUTE: begin
            if (!first_q && bus.pe_done_i) begin
               state_d = S_DRAIN;
               cnt_d   = ocount_q;
            end
         end
         S_DRAIN: begin
            if ((cnt_q == 8'd0) || (bus.outs_valid_i && (cnt_q == 8'd1))) begin
               state_d = S_DONE;
            end else if (bus.outs_valid_i) begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (bus.abort_i) begin
         state_d      = S_IDLE;
         cnt_d        = '0;
         x_d          = '0;
         y_d          = '0;
         k_d          = '0;
         addr_d       = '0;
         first_d      = 1'b0;
         cast_valid_d = 1'b0;
         tag_sel_w_d  = 1'b0;
         tag_x_d      = '0;
         tag_y_d      = '0;
      end
   end

   always_comb begin
      bus.id_wren_o       = (state_q == S_SCAN);
      bus.id_idx_o        = (state_q == S_SCAN) ? cnt_q : 8'd0;
      bus.w_rd_en_o       = rd_active && (state_q == S_LOADW);
      bus.a_rd_en_o       = rd_active && (state_q == S_LOADA);
      bus.w_rd_addr_o     = (rd_active && (state_q == S_LOADW)) ? addr_q : '0;
      bus.a_rd_addr_o     = (rd_active && (state_q == S_LOADA)) ? addr_q : '0;
      bus.tag_x_o         = tag_x_q;
      bus.tag_y_o         = tag_y_q;
      bus.tag_sel_w_o     = tag_sel_w_q;
      bus.cast_valid_o    = cast_valid_q;
      bus.start_compute_o = (state_q == S_COMPUTE) && first_q;
      bus.busy_o          = (state_q != S_IDLE);
      bus.done_o          = (state_q == S_DONE);
   end
endmodule

// File: tb/tb_cluster_sequencer.sv
// Bench for cluster_sequencer: directed and randomized jobs checked against
// expected scan/address/tag sequences and phase timings built from the job rules.
module tb_cluster_sequencer;
   localparam int NX = 3, NY = 3, IDW = 8, AW = 16;
   localparam int NPE = NX*NY;
   localparam int SCAN_LEN = NX*NY+NY;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   cluster_sequencer_if #(.idSize(IDW), .addrSize(AW)) bus();
   cluster_sequencer #(.numPeX(NX), .numPeY(NY), .idSize(IDW), .addrSize(AW)) dut (
      .clk(clk), .nrst(nrst), .bus(bus)
   );

   int n_checks = 0, n_pass = 0, n_fail = 0;

   logic [31:0] scan_q[$], waddr_q[$], aaddr_q[$], tag_q[$];
   int cyc = 0, last_scan_cyc = -1, first_w_cyc = -1, first_a_cyc = -1, sc_cyc = -1;
   int sc_cnt = 0, done_cnt = 0;
   logic prev_rd = 1'b0, prev_abort = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] all_outs();
      return {bus.busy_o, bus.done_o, bus.id_wren_o, bus.id_idx_o, bus.w_rd_en_o, bus.a_rd_en_o,
              bus.w_rd_addr_o, bus.a_rd_addr_o, bus.tag_x_o, bus.tag_y_o, bus.tag_sel_w_o,
              bus.cast_valid_o, bus.start_compute_o};
   endfunction

   function automatic int mx1(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   // Observer: cast_valid must follow a read strobe by one cycle unless aborted.
   always @(negedge clk) begin
      if (!nrst) begin
         prev_rd    = 1'b0;
         prev_abort = 1'b0;
      end else begin
         chk("cast_align", {63'd0, bus.cast_valid_o}, {63'd0, prev_rd && !prev_abort});
         prev_rd    = bus.w_rd_en_o | bus.a_rd_en_o;
         prev_abort = bus.abort_i;
         if (bus.id_wren_o) begin
            scan_q.push_back(32'(bus.id_idx_o));
            last_scan_cyc = cyc;
         end
         if (bus.w_rd_en_o) begin
            waddr_q.push_back(32'(bus.w_rd_addr_o));
            if (first_w_cyc < 0) first_w_cyc = cyc;
         end
         if (bus.a_rd_en_o) begin
            aaddr_q.push_back(32'(bus.a_rd_addr_o));
            if (first_a_cyc < 0) first_a_cyc = cyc;
         end
         if (bus.cast_valid_o) tag_q.push_back({15'd0, bus.tag_sel_w_o, bus.tag_y_o, bus.tag_x_o});
         if (bus.start_compute_o) begin
            sc_cnt++;
            sc_cyc = cyc;
         end
         if (bus.done_o) done_cnt++;
         cyc++;
      end
   end

   task automatic cmp_q(input string tag, input logic [31:0] obs[$], input logic [31:0] exp[$]);
      chk({tag, "_len"}, 64'(obs.size()), 64'(exp.size()));
      for (int i = 0; i < obs.size() && i < exp.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), 64'(obs[i]), 64'(exp[i]));
   endtask

   task automatic clear_obs();
      scan_q.delete(); waddr_q.delete(); aaddr_q.delete(); tag_q.delete();
      last_scan_cyc = -1; first_w_cyc = -1; first_a_cyc = -1; sc_cyc = -1;
      sc_cnt = 0; done_cnt = 0;
   endtask

   task automatic run_job(input int wc, input int ac, input int oc, input int wb, input int ab,
                          input bit pe_first, input bit start_in_cmp, input bit rst_drain);
      logic [31:0] es[$], ew[$], ea[$], et[$];
      int to, d;
      for (int i = SCAN_LEN-1; i >= 0; i--) es.push_back(32'(i));
      for (int y = 0; y < NY; y++)
         for (int x = 0; x < NX; x++)
            for (int k = 0; k < wc; k++) begin
               ew.push_back((wb + (y*NX+x)*wc + k) & 32'hFFFF);
               et.push_back({15'd0, 1'b1, 8'(y), 8'(x)});
            end
      for (int y = 0; y < NY; y++)
         for (int x = 0; x < NX; x++)
            for (int k = 0; k < ac; k++) begin
               ea.push_back((ab + (y*NX+x)*ac + k) & 32'hFFFF);
               et.push_back({15'd0, 1'b0, 8'(y), 8'(x)});
            end

      clear_obs();
      bus.cfg_wcount = 8'(wc);
      bus.cfg_acount = 8'(ac);
      bus.cfg_ocount = 8'(oc);
      bus.cfg_w_base = 16'(wb);
      bus.cfg_a_base = 16'(ab);
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      bus.cfg_wcount = 8'($urandom);
      bus.cfg_acount = 8'($urandom);
      bus.cfg_ocount = 8'($urandom);
      bus.cfg_w_base = 16'($urandom);
      bus.cfg_a_base = 16'($urandom);

      to = 0;
      while (!bus.start_compute_o && to < 3000) begin
         step();
         to++;
      end
      chk("compute_reached", 64'(to < 3000), 64'd1);
      if (to >= 3000) return;

      bus.pe_done_i = pe_first;
      bus.start_i = start_in_cmp;
      step();
      bus.pe_done_i = 1'b0;
      bus.start_i = 1'b0;
      chk("compute_held", {63'd0, bus.busy_o && !bus.done_o && !bus.start_compute_o}, 64'd1);
      d = $urandom_range(0, 3);
      repeat (d) step();
      bus.pe_done_i = 1'b1;
      step();
      bus.pe_done_i = 1'b0;

      if (rst_drain) begin
         bus.outs_valid_i = 1'b1;
         step();
         bus.outs_valid_i = 1'b0;
         #2 nrst = 1'b0;
         #1 chk("rst_drain_outs", all_outs(), 64'd0);
         step();
         step();
         nrst = 1'b1;
         repeat (10) step();
         chk("rst_drain_no_done", 64'(done_cnt), 64'd0);
         chk("rst_drain_idle", {63'd0, bus.busy_o}, 64'd0);
         return;
      end

      for (int i = 0; i < oc; i++) begin
         chk("drain_busy", {62'd0, bus.busy_o, bus.done_o}, 64'd2);
         repeat ($urandom_range(0, 2)) step();
         bus.outs_valid_i = 1'b1;
         step();
         bus.outs_valid_i = 1'b0;
      end
      if (oc == 0) step();
      chk("done_pulse", {62'd0, bus.done_o, bus.busy_o}, 64'd3);
      step();
      chk("after_done", {62'd0, bus.done_o, bus.busy_o}, 64'd0);
      step();

      cmp_q("scan", scan_q, es);
      cmp_q("waddr", waddr_q, ew);
      cmp_q("aaddr", aaddr_q, ea);
      cmp_q("tags", tag_q, et);
      chk("start_compute_cnt", 64'(sc_cnt), 64'd1);
      chk("done_cnt", 64'(done_cnt), 64'd1);
      if (wc > 0) chk("loadw_start", 64'(first_w_cyc), 64'(last_scan_cyc + 1));
      if (ac > 0) chk("loada_start", 64'(first_a_cyc), 64'(last_scan_cyc + 1 + mx1(NPE*wc)));
      chk("compute_start", 64'(sc_cyc), 64'(last_scan_cyc + 1 + mx1(NPE*wc) + mx1(NPE*ac)));
   endtask

   initial begin
      int to;
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      bus.pe_done_i = 1'b0;
      bus.outs_valid_i = 1'b0;
      bus.cfg_wcount = 8'd0;
      bus.cfg_acount = 8'd0;
      bus.cfg_ocount = 8'd0;
      bus.cfg_w_base = 16'd0;
      bus.cfg_a_base = 16'd0;
      #3 chk("reset_outs", all_outs(), 64'd0);
      step();
      nrst = 1'b1;
      step();
      chk("idle_outs", all_outs(), 64'd0);

      run_job(2, 2, 3, 16'h100, 16'h200, 1'b0, 1'b0, 1'b0);
      run_job(0, 2, 1, 16'h100, 16'h200, 1'b0, 1'b0, 1'b0);
      run_job(2, 1, 2, 16'hFFFF, 16'h0010, 1'b0, 1'b0, 1'b0);
      run_job(1, 0, 0, 16'h0042, 16'h0300, 1'b0, 1'b0, 1'b0);

      // Abort on the fifth activation-load cycle.
      clear_obs();
      bus.cfg_wcount = 8'd2;
      bus.cfg_acount = 8'd2;
      bus.cfg_ocount = 8'd3;
      bus.cfg_w_base = 16'h100;
      bus.cfg_a_base = 16'h200;
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      to = 0;
      while (!bus.a_rd_en_o && to < 500) begin
         step();
         to++;
      end
      chk("loada_reached", 64'(to < 500), 64'd1);
      repeat (4) step();
      bus.abort_i = 1'b1;
      step();
      bus.abort_i = 1'b0;
      chk("abort_outs", all_outs(), 64'd0);
      step();
      chk("abort_outs2", all_outs(), 64'd0);
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      chk("abort_aaddr_cnt", 64'(aaddr_q.size()), 64'd5);
      run_job(2, 2, 3, 16'h100, 16'h200, 1'b0, 1'b0, 1'b0);

      // pe_done on the first compute cycle and a stray start are both ignored.
      run_job(2, 2, 3, 16'h100, 16'h200, 1'b1, 1'b1, 1'b0);

      // Abort and start together while idle.
      bus.start_i = 1'b1;
      bus.abort_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      chk("abort_beats_start", all_outs(), 64'd0);
      step();
      chk("abort_beats_start2", all_outs(), 64'd0);

      for (int j = 0; j < 6; j++)
         run_job($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 65535), $urandom_range(0, 65535), 1'($urandom), 1'b0, 1'b0);

      run_job(2, 2, 3, 16'h100, 16'h200, 1'b0, 1'b0, 1'b1);
      run_job(1, 1, 1, 16'h0500, 16'h0600, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/cluster_sequencer.md
CLUSTER_SEQUENCER -- requirements
Module: cluster_sequencer

Interface
REQ-001 Parameters: numPeX, default 3, PE columns; numPeY, default 3, PE rows; idSize, default 8, multicast ID width; addrSize, default 16, memory address width.
REQ-002 Derived constant SCAN_LEN = numPeX*numPeY+numPeY; this is the ID-chain length per network.
REQ-003 clk  in  1  single clock, rising-edge.
REQ-004 nrst  in  1  asynchronous active-low reset.
REQ-005 start_i  in  1  single-cycle pulse that begins a full job; honored only in S_IDLE.
REQ-006 abort_i  in  1  synchronous abort.
REQ-007 cfg_wcount, cfg_acount  in  8 each  words per PE for weights and activations.
REQ-008 cfg_ocount  in  8  expected output-valid beats.
REQ-009 cfg_w_base, cfg_a_base  in  addrSize each  memory base addresses.
REQ-010 id_idx_o  out  8  ID-table index for the current scan beat.
REQ-011 id_wren_o  out  1  enables the ID scan chain shift.
REQ-012 w_rd_en_o, a_rd_en_o  out  1 each  memory read strobes.
REQ-013 w_rd_addr_o, a_rd_addr_o  out  addrSize each  read addresses.
REQ-014 tag_x_o, tag_y_o  out  idSize each  multicast tag targets, aligned to read data.
REQ-015 tag_sel_w_o  out  1  1 selects the weight networks, 0 selects the activation networks; aligned with the tags.
REQ-016 cast_valid_o  out  1  tags and read data valid this cycle.
REQ-017 start_compute_o  out  1  single-cycle compute trigger.
REQ-018 pe_done_i  in  1  PE array finished MACs.
REQ-019 outs_valid_i  in  1  one output beat accepted.
REQ-020 busy_o, done_o  out  1 each  busy level; done is a single-cycle pulse.

Function
REQ-021 States and order: S_IDLE -> S_SCAN -> S_LOADW -> S_LOADA -> S_COMPUTE -> S_DRAIN -> S_DONE -> S_IDLE.
REQ-022 S_SCAN: id_wren_o=1 for exactly SCAN_LEN cycles; id_idx_o counts SCAN_LEN-1 down to 0, so the last-shifted ID lands at chain index 0.
REQ-023 Load nesting, for both load states: y outer (0..numPeY-1), x middle (0..numPeX-1), k inner (0..count-1).
REQ-024 In S_LOADW, one read per cycle with w_rd_en_o=1 and w_rd_addr_o = cfg_w_base + (y*numPeX+x)*cfg_wcount + k.
REQ-025 Address arithmetic is modulo 2^addrSize, wrapping silently.
REQ-026 S_LOADA uses the same scheme with the a_* ports and cfg_acount.
REQ-027 Memory has 1-cycle read latency; tag_x_o, tag_y_o, tag_sel_w_o and cast_valid_o are registered one cycle after the matching read strobe, so the final beat's cast_valid_o occurs in the first cycle of the next state.
REQ-028 A load state whose count is 0 issues no reads and lasts exactly 1 cycle.
REQ-029 S_COMPUTE: start_compute_o pulses exactly once, on the first cycle; the state is held until pe_done_i=1. pe_done_i in that first cycle is ignored.
REQ-030 S_DRAIN: count outs_valid_i beats; leave when the count reaches cfg_ocount. cfg_ocount=0 leaves after 1 cycle.
REQ-031 S_DONE: done_o=1 for one cycle, then return to S_IDLE.
REQ-032 busy_o=1 in every state except S_IDLE.
REQ-033 Configuration is sampled into registers on an accepted start_i; config changes mid-job have no effect.
REQ-034 start_i outside S_IDLE is ignored.
REQ-035 abort_i in any non-idle state: next state S_IDLE; all strobes low the next cycle, and the pending delayed cast_valid_o is cancelled; no done_o.
REQ-036 abort_i and start_i together in S_IDLE: abort wins, state stays S_IDLE.
REQ-037 If the final drain beat arrives in the same cycle as abort_i, abort wins.

Reset
REQ-038 On nrst low, asynchronously: state S_IDLE; every output 0; all counters and sampled config 0.
REQ-039 Reset mid-job discards the job entirely.

Verification
REQ-040 Defaults, wcount=acount=2, bases 0x100/0x200, ocount=3: SCAN takes 12 cycles with id_idx 11..0; 18 weight reads at 0x100..0x111 and tags (0,0),(0,0),(1,0)...(2,2); 18 activation reads at 0x200..0x211; one start_compute_o; 3 outs_valid beats then done_o.
REQ-041 wcount=0: S_LOADW lasts 1 cycle with no w_rd_en_o; the activation load is unchanged.
REQ-042 cfg_w_base=0xFFFF, wcount=2: addresses are 0xFFFF, 0x0000, 0x0001, ...
REQ-043 abort_i on the 5th S_LOADA cycle: the next cycle has busy_o=0, all strobes 0, and no cast_valid_o; a new start_i then runs a clean job.
REQ-044 nrst asserted during S_DRAIN: outputs are 0 immediately, and done_o is never pulsed.
REQ-045 start_i pulsed during S_COMPUTE, and pe_done_i high on the first S_COMPUTE cycle: both are ignored; the job finishes once.
